// File: rtl/dsc_mul_param.sv
// rtl/dsc_mul_param.sv - deterministic stochastic-computing multiplier with start/busy/done
//
// Purpose:
//   Multiplies NUM_INPUTS unsigned SNG_WIDTH-bit operands exactly. Each operand
//   drives a unary comparator stream (s_i = ctr_i < xr_i). The counters are
//   chained odometer-style: ctr_0 is the fastest and each outer counter steps
//   when all inner counters sit at their maximum. Every combination of counter
//   values is visited once, so counting the AND of all streams gives the
//   integer product.
//
// Ports:
//   clk     in   1     system clock, rising edge
//   rst     in   1     synchronous active-high reset
//   start   in   1     begin a multiplication (sampled in IDLE only)
//   x       in   N*W   packed operands, operand i = x[i*W +: W]
//   busy    out  1     high while streams are running
//   done    out  1     one-cycle pulse, z valid
//   z       out  N*W   product, held until replaced by the next result
//   sn_out  out  1     current product stream bit, 0 outside RUN
//
// Optional feature macro: DSC_MUL_EARLY_SHUTOFF_EN
//   Ends RUN once the outermost stream has gone low for good, and skips RUN
//   entirely when any operand is zero. The result is identical; only the
//   latency shrinks.

module dsc_mul_param #(
  parameter int SNG_WIDTH  = 6,
  parameter int NUM_INPUTS = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [NUM_INPUTS*SNG_WIDTH-1:0] x,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_INPUTS*SNG_WIDTH-1:0] z,
  output logic                            sn_out
);

  localparam int W    = SNG_WIDTH;
  localparam int N    = NUM_INPUTS;
  localparam int ACCW = N * W;

  localparam logic [W-1:0] CTR_MAX = {W{1'b1}};
  localparam logic [W-1:0] CTR_ONE = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [N-1:0][W-1:0]       ctr_q, ctr_d;
  logic [N-1:0][W-1:0]       xr_q, xr_d;
  logic [ACCW-1:0]           acc_q, acc_d;
  logic [ACCW-1:0]           z_q, z_d;

  // lower_max[i]: all counters below i are at their maximum, i.e. ctr_i
  // steps this cycle. lower_max[0] is constant 1 so ctr_0 steps every cycle.
  logic [N-1:0]              lower_max;
  logic                      stream_and;
  logic                      last_cycle;
  logic [ACCW-1:0]           acc_inc;

`ifdef DSC_MUL_EARLY_SHUTOFF_EN
  logic                      any_zero;
`endif

  always_comb begin
    lower_max    = '0;
    lower_max[0] = 1'b1;
    for (int i = 1; i < N; i++) begin
      lower_max[i] = lower_max[i-1] & (ctr_q[i-1] == CTR_MAX);
    end
  end

  always_comb begin
    stream_and = 1'b1;
    for (int i = 0; i < N; i++) begin
      stream_and = stream_and & (ctr_q[i] < xr_q[i]);
    end
  end

  assign sn_out  = (state_q == ST_RUN) & stream_and;
  assign acc_inc = {{(ACCW-1){1'b0}}, sn_out};

`ifdef DSC_MUL_EARLY_SHUTOFF_EN
  // Once ctr_{N-1} reaches xr_{N-1} the outer stream is 0 for the rest of
  // the sweep, so nothing more can reach the accumulator.
  assign last_cycle = lower_max[N-1] & (ctr_q[N-1] == (xr_q[N-1] - CTR_ONE));

  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < N; i++) begin
      any_zero = any_zero | (x[i*W +: W] == '0);
    end
  end
`else
  assign last_cycle = lower_max[N-1] & (ctr_q[N-1] == CTR_MAX);
`endif

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    xr_d    = xr_q;
    acc_d   = acc_q;
    z_d     = z_q;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          xr_d    = x;
          ctr_d   = '0;
          acc_d   = '0;
          state_d = ST_RUN;
`ifdef DSC_MUL_EARLY_SHUTOFF_EN
          if (any_zero) begin
            z_d     = '0;
            state_d = ST_DONE;
          end
`endif
        end
      end

      ST_RUN: begin
        busy  = 1'b1;
        acc_d = acc_q + acc_inc;
        for (int i = 0; i < N; i++) begin
          if (lower_max[i]) begin
            ctr_d[i] = ctr_q[i] + CTR_ONE;
          end
        end
        if (last_cycle) begin
          // z must include this cycle's stream bit, so take the updated sum.
          z_d     = acc_q + acc_inc;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      xr_q    <= '0;
      acc_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      xr_q    <= xr_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
    end
  end

  assign z = z_q;

endmodule
